mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle MIPS main controller.
- Replaces per-instruction combinational decode with a state machine that sequences the shared datapath: one ALU, one unified memory port, IR, PC and register file.
- Supports the existing instruction set: R-type (incl. JR), LW, SW, BEQ, BNE, ADDI, ANDI, ORI, XORI, J, JAL, LUI.
- Handles a ready-handshaked memory with an optional timeout.

Parameters:
MEM_TIMEOUT, 0, max cycles waiting for mem_ready in any memory state; 0 disables the timeout.
TO_W, 8, width of the timeout counter; MEM_TIMEOUT must be < 2**TO_W.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]; 6'b001000 = JR
mem_ready  in  1  memory completed the current access this cycle
zero  in  1  ALU zero flag, valid in BRANCH
pc_en  out  1  PC load enable
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request, held until mem_ready
MemWrite  out  1  memory write request, held until mem_ready
IRWrite  out  1  IR load enable
RegDst  out  1  write-register select: 1=rd, 0=rt
MemtoReg  out  1  writeback select: 1=MDR, 0=ALUOut
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A select: 0=PC, 1=A register
ALUSrcB  out  2  ALU B select: 00=B, 01=const 4, 10=extended imm, 11=extended imm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct, 11 logical-immediate
ExtOp  out  1  1=sign-extend, 0=zero-extend
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A register (JR)
JalEn  out  1  write PC+4 to $31
LuiEn  out  1  select imm<<16 as the writeback value
state  out  4  current state, for debug
illegal_op  out  1  one-cycle pulse on an unsupported opcode
mem_err  out  1  one-cycle pulse on a memory timeout

Behaviour:
- Reset (async, rst_n=0): state=FETCH, timeout counter=0, all outputs 0 except ExtOp=1. Outputs are Moore, decoded from state; the only exceptions are pc_en and the mem_ready-qualified enables listed below.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and pc_en are asserted only in the cycle where mem_ready=1; the FSM then goes to DECODE.
  - Without mem_ready, the FSM holds and the counter increments.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> JR if funct=001000, else RTEXE.
  - 100011/101011 -> MEMADR.
  - 000100/000101 -> BRANCH.
  - 001000/001100/001101/001110/001111 -> IMMEXE.
  - 000010 -> JUMP.
  - 000011 -> JAL.
  - Any other opcode -> FETCH, with illegal_op pulsed for 1 cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=00; next MEMRD (LW) or MEMWR (SW).
- MEMRD: MemRead=1, IorD=1; advance to MEMWB on mem_ready.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
- MEMWR: MemWrite=1, IorD=1; advance to FETCH on mem_ready.
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RTWB.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - pc_en = zero for BEQ, ~zero for BNE.
  - Next FETCH.
- IMMEXE:
  - ALUSrcA=1, ALUSrcB=10.
  - ADDI: ExtOp=1, ALUOp=00.
  - ANDI/ORI/XORI: ExtOp=0, ALUOp=11.
  - LUI: ExtOp=0, LuiEn=1.
  - Next IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0; LuiEn held for LUI; next FETCH.
- JUMP: PCSource=10, pc_en=1; next FETCH.
- JAL: PCSource=10, pc_en=1, RegWrite=1, JalEn=1 (PC still holds PC+4 during this cycle); next FETCH.
- JR: PCSource=11, pc_en=1; next FETCH.
- Timeout counter:
  - Cleared on every state change.
  - Counts only in FETCH, MEMRD and MEMWR while mem_ready=0.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT: pulse mem_err, go to FETCH, and do not assert the pending IRWrite, pc_en or RegWrite.
  - A timeout in FETCH re-fetches the same PC.
  - mem_ready arriving in the same cycle as the count reaching MEM_TIMEOUT: mem_ready wins, no error.
- opcode and funct are sampled only in DECODE, BRANCH and IMMEXE/IMMWB; IR is stable there.
- Reset asserted mid-instruction: immediate return to FETCH; no partial RegWrite or MemWrite after the reset edge.
- CPI: R/imm 4, LW 5, SW 4, branch/jump/JR/JAL 3, plus memory wait cycles.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings (FETCH=0 … JR=13, 4 bits);
  - opcode and funct constants;
  - ALUOp, ALUSrcB and PCSource encodings.
- One natural sub-module, mc_mem_timer: the timeout counter with clear, enable and expire.

Test Plan:
- Reset: rst_n low mid-MEMRD -> state=0, all outputs 0 except ExtOp=1; after release, FETCH with MemRead=1.
- LW with mem_ready high after 2 waits in FETCH and 0 in MEMRD -> IRWrite pulses in cycle 3; sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1, MemtoReg=1 in MEMWB only.
- BNE with zero=1 -> pc_en=0 in BRANCH; BEQ with zero=1 -> pc_en=1, PCSource=01.
- R-type with funct=001000 -> DECODE then JR, PCSource=11, pc_en=1, no RegWrite; funct=100000 -> RTEXE/RTWB, RegDst=1.
- ORI then LUI -> IMMEXE has ExtOp=0, ALUOp=11; LUI has LuiEn=1 in both IMMEXE and IMMWB; JAL gives JalEn=1, RegWrite=1 for 1 cycle.
- Timeout and illegal opcode:
  - MEM_TIMEOUT=4, mem_ready held low in MEMWR -> mem_err pulses after 4 cycles, state returns to FETCH, no MemWrite afterward.
  - opcode 6'b111111 -> illegal_op pulse, then FETCH.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared constants for the multi-cycle MIPS controller: state codes, opcodes, mux selects.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mc_pkg;

   // Controller states; the numeric codes are visible on the debug state output.
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXE  = 4'd6,
      S_RTWB   = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEXE = 4'd9,
      S_IMMWB  = 4'd10,
      S_JUMP   = 4'd11,
      S_JAL    = 4'd12,
      S_JR     = 4'd13
   } state_t;

   // Opcodes (IR[31:26]) and the one funct code the controller cares about.
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // ALUOp encodings.
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_LOGIC = 2'b11;

   // ALUSrcB encodings.
   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_4     = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // PCSource encodings.
   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_REG    = 2'b11;

   // States that own the memory port and may wait on mem_ready.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory bundle: IR fields, flags and all control strobes.
// Latency: none (wiring only).
// Backpressure: mem_ready from the memory side stalls the controller in memory states.
// master = controller side (drives controls), slave = datapath/memory side.
interface mc_control_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       zero;
   logic       pc_en;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       ExtOp;
   logic [1:0] PCSource;
   logic       JalEn;
   logic       LuiEn;
   logic [3:0] state;
   logic       illegal_op;
   logic       mem_err;

   modport master (
      input  opcode, funct, mem_ready, zero,
      output pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, JalEn, LuiEn,
             state, illegal_op, mem_err
   );

   modport slave (
      output opcode, funct, mem_ready, zero,
      input  pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, JalEn, LuiEn,
             state, illegal_op, mem_err
   );
endinterface

// File: rtl/mc_control_fsm_mem_timer.sv
// Memory wait watchdog: counts stalled cycles and flags expiry at LIMIT (LIMIT=0 disables).
// Latency: o_expire is combinational from the registered count and i_en.
// Backpressure: none; counter saturates instead of wrapping.
// Ports: clk, rst_n; i_clr clears the count; i_en counts one stalled cycle; o_expire flags timeout.
module mc_mem_timer #(
   parameter int LIMIT = 0,
   parameter int W     = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Expiry needs a stalled cycle: a ready arriving at count==LIMIT drops i_en and wins.
   assign o_expire = (LIMIT != 0) && i_en && (r_cnt == LIM);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller sequencing one ALU, one memory port, IR, PC and regfile.
// Latency: 3-5 cycles per instruction plus memory wait cycles; outputs Moore except mem_ready/zero qualified enables.
// Backpressure: holds in FETCH/MEMRD/MEMWR until mem_ready; optional timeout aborts back to FETCH.
// Ports: clk, rst_n (async active-low); bus (master modport) carries opcode/funct/mem_ready/zero in
//        and all datapath controls, debug state, illegal_op and mem_err pulses out.
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0,
   parameter int TO_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mc_control_fsm_if.master  bus
);

   state_t     r_state;
   state_t     w_next;
   logic       r_is_sw;
   logic       w_expire;
   logic       w_tmr_en;
   logic       w_tmr_clr;

   logic       w_pc_en, w_iord, w_mem_read, w_mem_write, w_ir_write;
   logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a;
   logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;
   logic       w_ext_op, w_jal_en, w_lui_en, w_illegal, w_mem_err;

   // MEMADR must pick MEMRD/MEMWR without looking at the IR, so the load/store
   // choice is captured while decoding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_is_sw <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_is_sw <= (bus.opcode == OP_SW);
         end
      end
   end

   assign w_tmr_en  = is_mem_state(r_state) && !bus.mem_ready;
   // Clearing on expiry too lets a FETCH timeout restart counting for the re-fetch.
   assign w_tmr_clr = (w_next != r_state) || w_expire;

   mc_mem_timer #(
      .LIMIT (MEM_TIMEOUT),
      .W     (TO_W)
   ) u_mem_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (w_tmr_clr),
      .i_en     (w_tmr_en),
      .o_expire (w_expire)
   );

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:                                  w_next = (bus.funct == FN_JR) ? S_JR : S_RTEXE;
               OP_LW, OP_SW:                              w_next = S_MEMADR;
               OP_BEQ, OP_BNE:                            w_next = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_next = S_IMMEXE;
               OP_J:                                      w_next = S_JUMP;
               OP_JAL:                                    w_next = S_JAL;
               default:                                   w_next = S_FETCH;
            endcase
         end
         S_MEMADR: w_next = r_is_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (bus.mem_ready)  w_next = S_MEMWB;
            else if (w_expire)  w_next = S_FETCH;
         end
         S_MEMWR:  w_next = (bus.mem_ready || w_expire) ? S_FETCH : S_MEMWR;
         S_RTEXE:  w_next = S_RTWB;
         S_IMMEXE: w_next = S_IMMWB;
         default:  w_next = S_FETCH;
      endcase
   end

   // Output decode; while reset is asserted everything is forced quiet.
   always_comb begin
      w_pc_en      = 1'b0;
      w_iord       = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = SRCB_B;
      w_alu_op     = ALU_ADD;
      w_ext_op     = 1'b1;
      w_pc_source  = PCS_ALU;
      w_jal_en     = 1'b0;
      w_lui_en     = 1'b0;
      w_illegal    = 1'b0;
      w_mem_err    = 1'b0;
      if (rst_n) begin
         w_mem_err = w_expire;
         case (r_state)
            S_FETCH: begin
               w_mem_read  = 1'b1;
               w_alu_src_b = SRCB_4;
               w_ir_write  = bus.mem_ready;
               w_pc_en     = bus.mem_ready;
            end
            S_DECODE: begin
               w_alu_src_b = SRCB_IMMSH;
               case (bus.opcode)
                  OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
                  OP_ORI, OP_XORI, OP_LUI, OP_J, OP_JAL: w_illegal = 1'b0;
                  default:                               w_illegal = 1'b1;
               endcase
            end
            S_MEMADR: begin
               w_alu_src_a = 1'b1;
               w_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
               w_mem_read = 1'b1;
               w_iord     = 1'b1;
            end
            S_MEMWB: begin
               w_reg_write  = 1'b1;
               w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               w_mem_write = 1'b1;
               w_iord      = 1'b1;
            end
            S_RTEXE: begin
               w_alu_src_a = 1'b1;
               w_alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
               w_reg_write = 1'b1;
               w_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               w_alu_src_a = 1'b1;
               w_alu_op    = ALU_SUB;
               w_pc_source = PCS_ALUOUT;
               w_pc_en     = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
            end
            S_IMMEXE: begin
               w_alu_src_a = 1'b1;
               w_alu_src_b = SRCB_IMM;
               case (bus.opcode)
                  OP_ANDI, OP_ORI, OP_XORI: begin
                     w_ext_op = 1'b0;
                     w_alu_op = ALU_LOGIC;
                  end
                  OP_LUI: begin
                     w_ext_op = 1'b0;
                     w_lui_en = 1'b1;
                  end
                  default: w_ext_op = 1'b1;
               endcase
            end
            S_IMMWB: begin
               w_reg_write = 1'b1;
               w_lui_en    = (bus.opcode == OP_LUI);
            end
            S_JUMP: begin
               w_pc_source = PCS_JUMP;
               w_pc_en     = 1'b1;
            end
            S_JAL: begin
               w_pc_source = PCS_JUMP;
               w_pc_en     = 1'b1;
               w_reg_write = 1'b1;
               w_jal_en    = 1'b1;
            end
            S_JR: begin
               w_pc_source = PCS_REG;
               w_pc_en     = 1'b1;
            end
            default: w_ext_op = 1'b1;
         endcase
      end
   end

   assign bus.pc_en      = w_pc_en;
   assign bus.IorD       = w_iord;
   assign bus.MemRead    = w_mem_read;
   assign bus.MemWrite   = w_mem_write;
   assign bus.IRWrite    = w_ir_write;
   assign bus.RegDst     = w_reg_dst;
   assign bus.MemtoReg   = w_mem_to_reg;
   assign bus.RegWrite   = w_reg_write;
   assign bus.ALUSrcA    = w_alu_src_a;
   assign bus.ALUSrcB    = w_alu_src_b;
   assign bus.ALUOp      = w_alu_op;
   assign bus.ExtOp      = w_ext_op;
   assign bus.PCSource   = w_pc_source;
   assign bus.JalEn      = w_jal_en;
   assign bus.LuiEn      = w_lui_en;
   assign bus.state      = r_state;
   assign bus.illegal_op = w_illegal;
   assign bus.mem_err    = w_mem_err;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: instruction-level model builds expected per-cycle controls.
// Latency: n/a (bench).
// Backpressure: mem_ready wait counts are part of each directed instruction vector.
module tb_mc_control_fsm;

   localparam int TMO = 4;

   localparam logic [3:0] ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,
                          ST_MEMRD  = 4'd3,  ST_MEMWB  = 4'd4,  ST_MEMWR  = 4'd5,
                          ST_RTEXE  = 4'd6,  ST_RTWB   = 4'd7,  ST_BRANCH = 4'd8,
                          ST_IMMEXE = 4'd9,  ST_IMMWB  = 4'd10, ST_JUMP   = 4'd11,
                          ST_JAL    = 4'd12, ST_JR     = 4'd13;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101,
                          ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101,
                          XORI = 6'b001110, LUI = 6'b001111, J = 6'b000010, JAL = 6'b000011,
                          RTYPE = 6'b000000;

   typedef struct packed {
      logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, alu_op;
      logic       ext_op;
      logic [1:0] pc_source;
      logic       jal_en, lui_en;
      logic [3:0] st;
      logic       illegal_op, mem_err;
   } ctl_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mc_control_fsm_if bus();

   mc_control_fsm #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   ctl_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         err_pulses = 0;
   int         ill_pulses = 0;
   bit         done = 0;
   logic [5:0] cur_op = '0;
   logic [5:0] cur_fn = '0;
   logic       cur_z = 1'b0;
   int         n_lw, n_rt, n_jal, n_swto, n_jto, n_ill, n_swb;

   function automatic ctl_t idle(input logic [3:0] s);
      ctl_t c;
      c = '0;
      c.ext_op = 1'b1;
      c.st = s;
      return c;
   endfunction

   // Expected controls for one cycle of a memory-owning state.
   function automatic ctl_t mem_rec(input logic [3:0] s, input logic rdy, input logic err);
      ctl_t c;
      c = idle(s);
      c.mem_err = err;
      if (s == ST_FETCH) begin
         c.mem_read = 1'b1;
         c.alu_src_b = 2'b01;
         c.ir_write = rdy;
         c.pc_en = rdy;
      end else if (s == ST_MEMRD) begin
         c.mem_read = 1'b1;
         c.iord = 1'b1;
      end else begin
         c.mem_write = 1'b1;
         c.iord = 1'b1;
      end
      return c;
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op inside {RTYPE, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, XORI, LUI, J, JAL};
   endfunction

   function automatic ctl_t sample();
      ctl_t g;
      g.pc_en = bus.pc_en;       g.iord = bus.IorD;         g.mem_read = bus.MemRead;
      g.mem_write = bus.MemWrite; g.ir_write = bus.IRWrite;  g.reg_dst = bus.RegDst;
      g.mem_to_reg = bus.MemtoReg; g.reg_write = bus.RegWrite; g.alu_src_a = bus.ALUSrcA;
      g.alu_src_b = bus.ALUSrcB; g.alu_op = bus.ALUOp;      g.ext_op = bus.ExtOp;
      g.pc_source = bus.PCSource; g.jal_en = bus.JalEn;     g.lui_en = bus.LuiEn;
      g.st = bus.state;          g.illegal_op = bus.illegal_op; g.mem_err = bus.mem_err;
      return g;
   endfunction

   task automatic step(input logic rst, input logic mr, input ctl_t e);
      @(posedge clk);
      #1;
      rst_n = ~rst;
      bus.opcode = cur_op;
      bus.funct = cur_fn;
      bus.zero = cur_z;
      bus.mem_ready = mr;
      exp_q.push_back(e);
   endtask

   // A memory phase with 'waits' stalled cycles; the (TMO+1)-th consecutive stall aborts.
   task automatic mem_phase(input logic [3:0] s, input int waits, output bit aborted, inout int n);
      aborted = 1'b0;
      for (int k = 0; k <= waits; k++) begin
         n++;
         if (k < waits && k == TMO) begin
            step(1'b0, 1'b0, mem_rec(s, 1'b0, 1'b1));
            aborted = 1'b1;
            break;
         end else if (k < waits) begin
            step(1'b0, 1'b0, mem_rec(s, 1'b0, 1'b0));
         end else begin
            step(1'b0, 1'b1, mem_rec(s, 1'b1, 1'b0));
         end
      end
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                        input logic z, output int n);
      ctl_t e;
      bit   ab;
      int   w;
      n = 0;
      cur_op = op; cur_fn = fn; cur_z = z;
      w = fw;
      do begin
         mem_phase(ST_FETCH, w, ab, n);
         w = w - (TMO + 1);
      end while (ab);
      e = idle(ST_DECODE);
      e.alu_src_b = 2'b11;
      e.illegal_op = !legal(op);
      step(1'b0, 1'b0, e); n++;
      if (op == RTYPE && fn == 6'b001000) begin
         e = idle(ST_JR); e.pc_source = 2'b11; e.pc_en = 1'b1;
         step(1'b0, 1'b0, e); n++;
      end else if (op == RTYPE) begin
         e = idle(ST_RTEXE); e.alu_src_a = 1'b1; e.alu_op = 2'b10;
         step(1'b0, 1'b0, e); n++;
         e = idle(ST_RTWB); e.reg_write = 1'b1; e.reg_dst = 1'b1;
         step(1'b0, 1'b0, e); n++;
      end else if (op == LW || op == SW) begin
         e = idle(ST_MEMADR); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
         step(1'b0, 1'b0, e); n++;
         mem_phase((op == LW) ? ST_MEMRD : ST_MEMWR, mw, ab, n);
         if (op == LW && !ab) begin
            e = idle(ST_MEMWB); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            step(1'b0, 1'b0, e); n++;
         end
      end else if (op == BEQ || op == BNE) begin
         e = idle(ST_BRANCH); e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
         e.pc_en = (op == BEQ) ? z : !z;
         step(1'b0, 1'b0, e); n++;
      end else if (op inside {ADDI, ANDI, ORI, XORI, LUI}) begin
         e = idle(ST_IMMEXE); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
         e.ext_op = (op == ADDI);
         e.alu_op = (op inside {ANDI, ORI, XORI}) ? 2'b11 : 2'b00;
         e.lui_en = (op == LUI);
         step(1'b0, 1'b0, e); n++;
         e = idle(ST_IMMWB); e.reg_write = 1'b1; e.lui_en = (op == LUI);
         step(1'b0, 1'b0, e); n++;
      end else if (op == J || op == JAL) begin
         e = idle((op == J) ? ST_JUMP : ST_JAL); e.pc_source = 2'b10; e.pc_en = 1'b1;
         e.reg_write = (op == JAL); e.jal_en = (op == JAL);
         step(1'b0, 1'b0, e); n++;
      end
   endtask

   // LW interrupted by reset during a MEMRD stall.
   task automatic reset_mid_memrd();
      ctl_t e;
      cur_op = LW; cur_fn = '0; cur_z = 1'b0;
      step(1'b0, 1'b1, mem_rec(ST_FETCH, 1'b1, 1'b0));
      e = idle(ST_DECODE); e.alu_src_b = 2'b11;
      step(1'b0, 1'b0, e);
      e = idle(ST_MEMADR); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      step(1'b0, 1'b0, e);
      step(1'b0, 1'b0, mem_rec(ST_MEMRD, 1'b0, 1'b0));
      step(1'b1, 1'b0, idle(ST_FETCH));
   endtask

   task automatic chk(input string name, input int got, input int expv);
      total++;
      if (got != expv) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, expv);
      end
   endtask

   // Single compare process: reset literals, per-cycle model checks, end-of-run literals.
   initial begin
      ctl_t g, e;
      forever begin
         @(negedge clk);
         cyc++;
         g = sample();
         if (cyc == 2) begin
            chk("rst_state", int'(g.st), 0);
            chk("rst_memread", int'(g.mem_read), 0);
            chk("rst_extop", int'(g.ext_op), 1);
         end
         if (g.mem_err) err_pulses++;
         if (g.illegal_op) ill_pulses++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin
               bad++;
               $display("FAIL cycle %0d ctl: state got=%0d exp=%0d vec got=%h exp=%h",
                        cyc, g.st, e.st, g, e);
            end
         end
         if (done && exp_q.size() == 0) break;
         if (cyc > 5000) begin
            total++; bad++;
            $display("FAIL watchdog got=%0d cycles exp=under 5000", cyc);
            break;
         end
      end
      chk("cpi_lw_2wait", n_lw, 7);
      chk("cpi_rtype", n_rt, 4);
      chk("cpi_jal", n_jal, 3);
      chk("cyc_sw_timeout", n_swto, 8);
      chk("cyc_fetch_timeout_j", n_jto, 10);
      chk("cyc_illegal", n_ill, 2);
      chk("cyc_sw_boundary", n_swb, 8);
      chk("mem_err_pulses", err_pulses, 3);
      chk("illegal_pulses", ill_pulses, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int n;
      rst_n = 1'b0;
      bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      instr(LW,    6'd0,      2, 0, 1'b0, n_lw);
      instr(BNE,   6'd0,      0, 0, 1'b1, n);
      instr(BEQ,   6'd0,      0, 0, 1'b1, n);
      instr(BEQ,   6'd0,      1, 0, 1'b0, n);
      instr(BNE,   6'd0,      0, 0, 1'b0, n);
      instr(RTYPE, 6'b001000, 0, 0, 1'b0, n);
      instr(RTYPE, 6'b100000, 0, 0, 1'b0, n_rt);
      instr(ORI,   6'd0,      0, 0, 1'b0, n);
      instr(LUI,   6'd0,      0, 0, 1'b0, n);
      instr(ADDI,  6'd0,      1, 0, 1'b0, n);
      instr(ANDI,  6'd0,      0, 0, 1'b0, n);
      instr(XORI,  6'd0,      0, 0, 1'b0, n);
      instr(J,     6'd0,      0, 0, 1'b0, n);
      instr(JAL,   6'd0,      0, 0, 1'b0, n_jal);
      instr(SW,    6'd0,      0, 2, 1'b0, n);
      instr(SW,    6'd0,      0, 6, 1'b0, n_swto);
      instr(SW,    6'd0,      0, 4, 1'b0, n_swb);
      instr(J,     6'd0,      7, 0, 1'b0, n_jto);
      instr(LW,    6'd0,      0, 5, 1'b0, n);
      instr(6'b111111, 6'd0,  0, 0, 1'b0, n_ill);
      instr(LW,    6'd0,      0, 3, 1'b0, n);
      reset_mid_memrd();
      instr(LW,    6'd0,      0, 1, 1'b0, n);
      done = 1'b1;
   end

endmodule
